exec_stage: RTL and testbench
=============================

# exec_stage

Execute/write-back stage for the 4×8-bit register bank. It accepts two operand bytes (read ports rd0/rd1), an opcode and a destination address. It computes the result: a single-cycle ALU op, or an 8-cycle iterative multiply. It then drives the bank's write port (wr_en, add_wr, wr_data) for exactly one cycle per operation, with valid/ready handshake toward the upstream decode logic.

## Interface
- W, 8, data width; must match the bank width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  stage can accept; high only in IDLE
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (pass b), 110 MUL, 111 NOP
- a  in  W  operand A (bank rd0)
- b  in  W  operand B (bank rd1)
- dst  in  2  destination register address
- wr_en  out  1  bank write enable, one-cycle pulse
- add_wr  out  2  bank write address
- wr_data  out  W  bank write data
- zero  out  1  registered flag: last written result == 0
- carry  out  1  registered flag, see Operation
- busy  out  1  high in MUL and WB states

## Operation
- Clock is clk. Reset is synchronous, active-high, on rst.
- FSM states: IDLE, MUL, WB.
- IDLE: in_ready=1. Handshake fires on the edge where in_valid && in_ready. That edge latches op, a, b and dst.
  - Single-cycle op or NOP: next state is WB.
  - MUL: next state is MUL, and the counter is loaded with W-1.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Accumulator is 2W bits. Leaves for WB after W cycles.
- WB:
  - wr_en=1, add_wr=latched dst, wr_data=result.
  - NOP: wr_en=0 and flags unchanged.
  - Always returns to IDLE next cycle.
- Results are truncated to W bits.
  - ADD: a+b. carry = bit W of the sum.
  - SUB: a−b mod 2^W. carry = borrow (1 when a<b).
  - AND/OR/XOR/MOV: carry=0.
  - MUL: low W bits of a×b. carry=1 if the high W bits are non-zero.
- zero/carry update on the edge that ends WB, for every op except NOP.
- in_ready=0 during WB. No read can be issued while the bank write is pending, so no bypass is needed.
- in_valid while not ready is ignored. Upstream holds its operation until accepted.
- rst in any state:
  - Next state IDLE. Any in-flight MUL is discarded with no write.
  - wr_en, add_wr, wr_data, zero, carry, busy all go to 0.
- rst and in_valid in the same cycle: rst wins and nothing is accepted.

## Timing
- Single-cycle op accepted at edge n: wr_en high in cycle n..n+1, in_ready back high after edge n+1. Throughput is 1 op per 2 cycles.
- MUL accepted at edge n: busy for W+1 cycles, wr_en high in the cycle after edge n+W, in_ready high after edge n+W+1.
- Write lands in the bank at the edge that ends WB. Flags become visible at that same edge.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- After reset release: in_ready=1 in the first cycle.

## Structure
- Shared package exec_pkg:
  - op_t enum (ADD..NOP, 3 bits).
  - state_t enum (IDLE, MUL, WB).
  - Constant DATA_W=8, shared with the bank.
- Sub-module mul_iter:
  - Inputs: clk, rst, start, a, b.
  - Outputs: done (one-cycle pulse), prod [2W-1:0].
  - Shift-add with a log2(W)-bit counter.
- Top-level holds the FSM, combinational ALU, operand/dst latches and flag registers.

## Test plan
- Reset: assert rst for 2 cycles mid-MUL (accepted 3 cycles earlier) -> no wr_en pulse; wr_en=0, zero=0, carry=0, busy=0; in_ready=1 the cycle after release.
- ADD 0xF0+0x20, dst=2 -> wr_en pulse exactly 1 cycle, add_wr=2, wr_data=0x10, carry=1, zero=0; in_ready low during WB.
- SUB 0x05−0x05 then SUB 0x03−0x04 -> first: wr_data=0x00, zero=1, carry=0. Second: wr_data=0xFF, carry=1, zero=0.
- MUL 0x0C×0x0B, dst=1 -> wr_en in cycle 9 after accept, wr_data=0x84, carry=0. MUL 0x10×0x10 -> wr_data=0x00, carry=1, zero=1.
- NOP after ADD giving zero=1 -> no wr_en pulse; flags keep prior values; in_ready returns after 2 cycles.
- Back-to-back: hold in_valid with XOR 0xAA^0x55 then OR 0x0F|0x30 -> second accepted only after WB; writes 0xFF then 0x3F on consecutive odd cycles; nothing accepted while busy=1.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcode/state types and data width for the execute stage and register bank
package exec_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_MUL, OP_NOP} op_t;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier, one multiplier bit per cycle, LSB first
module mul_iter
  import exec_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);
  localparam int CW = $clog2(W);
  logic [W-1:0] mcand;
  logic [CW-1:0] cnt;
  logic run;
  logic [W:0] sum;
  // upper half accumulates, lower half holds the not-yet-consumed multiplier bits
  assign sum = {1'b0, prod[2*W-1:W]} + {1'b0, prod[0] ? mcand : '0};
  assign done = run && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      prod <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(W - 1);
      mcand <= a;
      prod <= {{W{1'b0}}, b};
    end else if (run) begin
      prod <= {sum, prod[W-1:1]};
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
    end
  end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute/write-back stage driving the register bank write port
module exec_stage
  import exec_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   dst,
  output logic         wr_en,
  output logic [1:0]   add_wr,
  output logic [W-1:0] wr_data,
  output logic         zero,
  output logic         carry,
  output logic         busy
);
  state_t state, nxt;
  op_t op_q;
  logic [W-1:0] a_q, b_q, res;
  logic [1:0] dst_q;
  logic [W:0] sum, diff;
  logic [2*W-1:0] prod;
  logic cy, mul_done, fire, wb;
  assign fire = in_valid && in_ready;
  mul_iter #(.W(W)) u_mul (
    .clk(clk), .rst(rst), .start(fire && op == OP_MUL), .a(a), .b(b),
    .done(mul_done), .prod(prod)
  );
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  always_comb begin
    res = op_q == OP_ADD ? sum[W-1:0] :
          op_q == OP_SUB ? diff[W-1:0] :
          op_q == OP_AND ? a_q & b_q :
          op_q == OP_OR  ? a_q | b_q :
          op_q == OP_XOR ? a_q ^ b_q :
          op_q == OP_MOV ? b_q :
          op_q == OP_MUL ? prod[W-1:0] : '0;
    cy = op_q == OP_ADD ? sum[W] :
         op_q == OP_SUB ? diff[W] :
         op_q == OP_MUL ? |prod[2*W-1:W] : 1'b0;
  end
  always_comb begin
    nxt = state == IDLE ? (fire ? (op == OP_MUL ? MUL : WB) : IDLE) :
          state == MUL  ? (mul_done ? WB : MUL) : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_NOP;
      a_q <= '0;
      b_q <= '0;
      dst_q <= '0;
    end else if (fire) begin
      op_q <= op_t'(op);
      a_q <= a;
      b_q <= b;
      dst_q <= dst;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      carry <= 1'b0;
    end else if (wr_en) begin
      zero <= res == '0;
      carry <= cy;
    end
  end
  assign wb = state == WB;
  assign in_ready = state == IDLE;
  assign busy = state == MUL || wb;
  assign wr_en = wb && op_q != OP_NOP;
  assign add_wr = wb ? dst_q : '0;
  assign wr_data = wr_en ? res : '0;
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed self-checking bench for exec_stage
module tb_exec_stage;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [2:0] op = 3'b111;
  logic [7:0] a = '0, b = '0;
  logic [1:0] dst = '0;
  logic in_ready, wr_en, zero, carry, busy;
  logic [1:0] add_wr;
  logic [7:0] wr_data;
  int n_checks = 0, n_fail = 0, k;

  exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .dst(dst), .wr_en(wr_en), .add_wr(add_wr), .wr_data(wr_data),
    .zero(zero), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [1:0] d);
    int w;
    op = o; a = x; b = y; dst = d; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    chk("ready_wait", 16'(w < 50), 16'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int exp_cycles);
    k = 0;
    while (!wr_en && k < 30) begin
      step();
      k++;
    end
    chk(tag, 16'(k), 16'(exp_cycles));
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 16'(in_ready), 16'd1);
    chk("rst_wr_en", 16'(wr_en), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_zero", 16'(zero), 16'd0);
    chk("rst_carry", 16'(carry), 16'd0);
    chk("rst_data", 16'(wr_data), 16'd0);
    // ADD with carry out
    issue(3'b000, 8'hF0, 8'h20, 2'd2);
    chk("add_wr_en", 16'(wr_en), 16'd1);
    chk("add_addr", 16'(add_wr), 16'd2);
    chk("add_data", 16'(wr_data), 16'h10);
    chk("add_ready_wb", 16'(in_ready), 16'd0);
    chk("add_busy_wb", 16'(busy), 16'd1);
    step();
    chk("add_pulse_end", 16'(wr_en), 16'd0);
    chk("add_carry", 16'(carry), 16'd1);
    chk("add_zero", 16'(zero), 16'd0);
    chk("add_ready_back", 16'(in_ready), 16'd1);
    // SUB equal and SUB with borrow
    issue(3'b001, 8'h05, 8'h05, 2'd0);
    chk("sub0_data", 16'(wr_data), 16'h00);
    step();
    chk("sub0_zero", 16'(zero), 16'd1);
    chk("sub0_carry", 16'(carry), 16'd0);
    issue(3'b001, 8'h03, 8'h04, 2'd3);
    chk("sub1_data", 16'(wr_data), 16'hFF);
    chk("sub1_addr", 16'(add_wr), 16'd3);
    step();
    chk("sub1_carry", 16'(carry), 16'd1);
    chk("sub1_zero", 16'(zero), 16'd0);
    // MUL 12*11 = 132
    issue(3'b110, 8'h0C, 8'h0B, 2'd1);
    chk("mul0_busy", 16'(busy), 16'd1);
    chk("mul0_ready", 16'(in_ready), 16'd0);
    wait_wr("mul0_latency", 8);
    chk("mul0_data", 16'(wr_data), 16'h84);
    chk("mul0_addr", 16'(add_wr), 16'd1);
    chk("mul0_busy_wb", 16'(busy), 16'd1);
    step();
    chk("mul0_carry", 16'(carry), 16'd0);
    chk("mul0_zero", 16'(zero), 16'd0);
    chk("mul0_ready_back", 16'(in_ready), 16'd1);
    // MUL 16*16 with an ADD held valid throughout; ADD must wait for WB
    issue(3'b110, 8'h10, 8'h10, 2'd2);
    op = 3'b000; a = 8'h01; b = 8'h01; dst = 2'd3; in_valid = 1'b1;
    wait_wr("mul1_latency", 8);
    chk("mul1_data", 16'(wr_data), 16'h00);
    chk("mul1_addr", 16'(add_wr), 16'd2);
    step();
    chk("mul1_carry", 16'(carry), 16'd1);
    chk("mul1_zero", 16'(zero), 16'd1);
    chk("mul1_gap", 16'(wr_en), 16'd0);
    step();
    in_valid = 1'b0;
    chk("queued_add_data", 16'(wr_data), 16'h02);
    chk("queued_add_addr", 16'(add_wr), 16'd3);
    step();
    // ADD to zero with carry, then NOP must keep both flags
    issue(3'b000, 8'h80, 8'h80, 2'd0);
    step();
    chk("addz_zero", 16'(zero), 16'd1);
    chk("addz_carry", 16'(carry), 16'd1);
    issue(3'b111, 8'h12, 8'h34, 2'd1);
    chk("nop_wr_en", 16'(wr_en), 16'd0);
    chk("nop_ready", 16'(in_ready), 16'd0);
    step();
    chk("nop_ready_back", 16'(in_ready), 16'd1);
    chk("nop_zero", 16'(zero), 16'd1);
    chk("nop_carry", 16'(carry), 16'd1);
    // reset mid-MUL discards the write and clears flags
    issue(3'b110, 8'h03, 8'h03, 2'd2);
    step();
    step();
    step();
    rst = 1'b1;
    in_valid = 1'b1; op = 3'b000; a = 8'h01; b = 8'h02;
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mrst_ready", 16'(in_ready), 16'd1);
    chk("mrst_wr_en", 16'(wr_en), 16'd0);
    chk("mrst_busy", 16'(busy), 16'd0);
    chk("mrst_zero", 16'(zero), 16'd0);
    chk("mrst_carry", 16'(carry), 16'd0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      k += int'(wr_en);
    end
    chk("mrst_no_write", 16'(k), 16'd0);
    // back-to-back with in_valid held
    op = 3'b100; a = 8'hAA; b = 8'h55; dst = 2'd1; in_valid = 1'b1;
    step();
    chk("b2b_xor_wr", 16'(wr_en), 16'd1);
    chk("b2b_xor_data", 16'(wr_data), 16'hFF);
    chk("b2b_ready_wb", 16'(in_ready), 16'd0);
    op = 3'b011; a = 8'h0F; b = 8'h30; dst = 2'd2;
    step();
    chk("b2b_gap_wr", 16'(wr_en), 16'd0);
    chk("b2b_gap_ready", 16'(in_ready), 16'd1);
    chk("b2b_xor_carry", 16'(carry), 16'd0);
    step();
    in_valid = 1'b0;
    chk("b2b_or_wr", 16'(wr_en), 16'd1);
    chk("b2b_or_data", 16'(wr_data), 16'h3F);
    chk("b2b_or_addr", 16'(add_wr), 16'd2);
    step();
    chk("b2b_done_wr", 16'(wr_en), 16'd0);
    chk("b2b_zero", 16'(zero), 16'd0);
    chk("b2b_idle", 16'(busy), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
